mac_accumulator: RTL and testbench



---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_sat_adder.sv | 30 +++
 rtl/mac_accumulator.sv | 100 ++++++++++
 tb/tb_mac_accumulator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate back end.
// Holds the default product width, the FSM state encoding and the saturation ceiling helper.
package mac_pkg;

    localparam int PROD_W_DEF = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Largest representable accumulator value for a given width (all ones).
    function automatic logic [63:0] acc_max(input int acc_w);
        return (64'd1 << acc_w) - 64'd1;
    endfunction

endpackage

// File: rtl/mac_sat_adder.sv
// Combinational accumulator + product adder returning the wrapped or clamped sum and the carry.
// Build option: define MAC_ACCUMULATOR_SAT_EN to clamp the sum at the accumulator ceiling on carry-out.
module mac_sat_adder
    import mac_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide_sum;

    assign wide_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    assign carry    = wide_sum[ACC_W];

`ifdef MAC_ACCUMULATOR_SAT_EN
    localparam logic [63:0]      MAX_FULL = acc_max(ACC_W);
    localparam logic [ACC_W-1:0] SAT_VAL  = MAX_FULL[ACC_W-1:0];

    // Once clamped, any further non-zero product carries again, so the sum stays pinned.
    assign sum = carry ? SAT_VAL : wide_sum[ACC_W-1:0];
`else
    assign sum = wide_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Packet accumulator: sums products until in_last (or max length) and offers sum/count/overflow.
// Build option: MAC_ACCUMULATOR_SAT_EN (handled inside mac_sat_adder) selects saturating accumulation.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    // Count value on the beat that makes the packet reach its maximum length.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W - 1){1'b1}}, 1'b0};

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_reg, ovf_next;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;

    mac_sat_adder #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_adder (
        .acc     (acc_reg),
        .product (in_product),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        if (clr) begin
            // Clear wins over both a beat and a result handshake.
            state_next = ACCUM;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (in_valid) begin
                        acc_next = add_sum;
                        cnt_next = cnt_reg + CNT_W'(1);
                        ovf_next = ovf_reg | add_carry;
                        if (in_last || (cnt_reg == CNT_LAST)) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = ACCUM;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    assign in_ready     = (state_reg == ACCUM);
    assign out_valid    = (state_reg == DONE);
    assign out_sum      = acc_reg;
    assign out_count    = cnt_reg;
    assign out_overflow = ovf_reg;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator with a narrow accumulator (17 bits) and 2-bit term counter.
// Expected results come from whole-packet integer arithmetic; a negedge monitor pops and compares.
module tb_mac_accumulator;

    localparam int    PROD_W = 16;
    localparam int    ACC_W  = 17;
    localparam int    CNT_W  = 2;
    localparam int    MAXT   = (1 << CNT_W) - 1;
    localparam longint MOD   = longint'(1) << ACC_W;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_overflow;

    mac_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        int     cnt;
        bit     ovf;
    } res_t;

    res_t   exp_q[$];
    longint pkt_total;
    int     pkt_cnt;
    int     n_checks;
    int     n_fail;
    int     ready_mode;   // 0: hold low, 1: hold high, 2: random

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: the packet result is just the plain integer total, then wrapped or clamped.
    task automatic push_expected();
        res_t r;
        r.cnt = pkt_cnt;
        r.ovf = (pkt_total >= MOD);
`ifdef MAC_ACCUMULATOR_SAT_EN
        r.sum = r.ovf ? (MOD - 1) : pkt_total;
`else
        r.sum = pkt_total % MOD;
`endif
        exp_q.push_back(r);
        $display("packet queued: terms=%0d total=%0d expect_sum=%0d ovf=%0d", r.cnt, pkt_total, r.sum, r.ovf);
        pkt_total = 0;
        pkt_cnt   = 0;
    endtask

    task automatic send_beat(input int prod, input bit last);
        int guard;
        guard      = 0;
        in_valid   = 1'b1;
        in_product = prod[PROD_W-1:0];
        in_last    = last;
        while (!in_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept_timeout: in_ready=%0d, expected 1 within 300 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        pkt_total += longint'(prod);
        pkt_cnt++;
        if (last || pkt_cnt == MAXT) push_expected();
    endtask

    task automatic drain();
        int guard;
        guard      = 0;
        ready_mode = 1;
        while ((exp_q.size() != 0 || !in_ready) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: a handshake will occur at the next rising edge; compare the held result now.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got sum %0d count %0d, expected no result", out_sum, out_count);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                $display("result: sum=%0d count=%0d ovf=%0d (expect %0d/%0d/%0d)",
                         out_sum, out_count, out_overflow, r.sum, r.cnt, r.ovf);
                chk("result_sum", longint'(out_sum), r.sum);
                chk("result_count", longint'(out_count), longint'(r.cnt));
                chk("result_overflow", longint'(out_overflow), longint'(r.ovf));
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        clr        = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        ready_mode = 0;
        pkt_total  = 0;
        pkt_cnt    = 0;
        n_checks   = 0;
        n_fail     = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_sum", longint'(out_sum), 0);
        chk("reset_out_count", longint'(out_count), 0);
        chk("reset_out_overflow", longint'(out_overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic packet: 225 + 65025 + 1.
        ready_mode = 1;
        send_beat(225, 1'b0);
        send_beat(65025, 1'b0);
        send_beat(1, 1'b1);
        chk("basic_out_valid_latency", longint'(out_valid), 1);
        drain();
        chk("basic_in_ready_after", longint'(in_ready), 1);

        // Backpressure with an ignored beat presented while the result is held.
        ready_mode = 0;
        @(posedge clk); #1;
        send_beat(225, 1'b0);
        send_beat(65025, 1'b0);
        send_beat(1, 1'b1);
        in_valid   = 1'b1;
        in_product = 16'd7;
        in_last    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_out_sum", longint'(out_sum), 65251);
            chk("bp_out_count", longint'(out_count), 3);
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        ready_mode = 1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", longint'(in_ready), 1);
        chk("bp_release_out_valid", longint'(out_valid), 0);
        chk("bp_release_sum_cleared", longint'(out_sum), 0);
        chk("bp_release_count_cleared", longint'(out_count), 0);

        // Overflow: three maximum products exceed 2^17-1.
        send_beat(65025, 1'b0);
        send_beat(65025, 1'b0);
        send_beat(65025, 1'b1);
        drain();

        // Clear mid-packet, with a beat presented alongside clr that must be discarded.
        send_beat(5, 1'b0);
        send_beat(6, 1'b0);
        clr        = 1'b1;
        in_valid   = 1'b1;
        in_product = 16'd99;
        @(posedge clk); #1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        pkt_total = 0;
        pkt_cnt   = 0;
        chk("clr_in_ready", longint'(in_ready), 1);
        chk("clr_count_cleared", longint'(out_count), 0);
        chk("clr_sum_cleared", longint'(out_sum), 0);
        send_beat(10, 1'b1);
        drain();

        // Maximum length: three beats without in_last force the result; the 4th beat must stall.
        ready_mode = 0;
        @(posedge clk); #1;
        send_beat(1, 1'b0);
        send_beat(1, 1'b0);
        send_beat(1, 1'b0);
        chk("maxlen_out_valid", longint'(out_valid), 1);
        chk("maxlen_out_count", longint'(out_count), 3);
        in_valid   = 1'b1;
        in_product = 16'd1;
        in_last    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("maxlen_stall_in_ready", longint'(in_ready), 0);
        end
        @(posedge clk); #1;
        ready_mode = 1;
        send_beat(1, 1'b0);
        send_beat(5, 1'b1);
        drain();

        // Randomized packets with random downstream backpressure.
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) begin
                send_beat(int'($urandom_range(0, 65025)), (i == len - 1));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
